cmp_arbiter: RTL and testbench
==============================

Name: cmp_arbiter

Overview:
Shares one signed comparator datapath (ops: 00 = signed less-than, 01 = signed greater-than, 10/11 = result 0) between NUM_REQ requesters.
- Round-robin arbitration with valid/ready request handshakes.
- Single registered result slot with per-requester response handshake.
- Sits between the decode/branch units and the comparator, so one comparator serves SLT-type ops and branch evaluation.

Parameters:
NUM_REQ, 2, number of requesters (1..4).
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  NUM_REQ  request valid, one bit per requester.
req_ready  out  NUM_REQ  grant/accept, at most one bit high per cycle.
req_src1  in  NUM_REQ*32  operand 1; requester i occupies bits [32i+31:32i].
req_src2  in  NUM_REQ*32  operand 2, packed as req_src1.
req_op  in  NUM_REQ*2  op code; requester i occupies bits [2i+1:2i].
rsp_valid  out  NUM_REQ  result valid, one-hot to the owning requester.
rsp_ready  in  NUM_REQ  requester accepts its result.
rsp_data  out  32  comparison result: 32'd1 or 32'd0.
rsp_illegal  out  1  set with the result when the op was 10 or 11.
op_count  out  CNT_W  number of results drained; wraps modulo 2^CNT_W.

Behaviour:
- One clock domain, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - rsp_valid = 0, rsp_data = 0, rsp_illegal = 0.
  - Owner register = 0, round-robin pointer rr_ptr = 0, op_count = 0.
- A reset during an operation discards any held result and any request in flight. No response follows after reset release.
- Slot states:
  - EMPTY: rsp_valid all 0.
  - FULL: exactly one rsp_valid bit high, equal to the owner.
- Slot "free this cycle" is true when the slot is EMPTY, or when it is FULL and rsp_ready[owner] = 1 (drain).
- Arbitration (combinational):
  - If the slot is free, scan req_valid starting at index rr_ptr, ascending with wrap. The first set bit i gets req_ready[i] = 1.
  - All other req_ready bits are 0.
  - If the slot is not free, all req_ready bits are 0.
- req_ready depends on req_valid. Requesters must not make valid depend on ready.
- Transfer is req_valid[i] & req_ready[i]. On a transfer, at the next edge:
  - rsp_data = compare(src1_i, src2_i, op_i), using signed 32-bit compare.
  - rsp_illegal = op_i[1].
  - Owner = i, rsp_valid = one-hot(i).
  - rr_ptr = (i+1) mod NUM_REQ.
- Latency is 1 cycle from transfer to rsp_valid.
- Drain and accept in the same cycle:
  - The slot reloads with the new result and rsp_valid moves to the new owner.
  - Throughput is 1 op/cycle.
  - The same requester can drain and re-issue back-to-back only when it is first in round-robin order after rr_ptr.
- Drain with no accept: slot goes EMPTY, rsp_data and rsp_illegal hold their last values.
- A FULL slot with rsp_ready[owner] = 0 holds all outputs stable. rsp_ready bits of non-owners are ignored.
- op_count increments by 1 on each drain and wraps from all-ones to 0. Illegal ops count too.
- rr_ptr changes only on a transfer. Idle cycles do not rotate priority.
- Edge cases:
  - NUM_REQ = 1: the arbiter degenerates to a pass-through handshake.
  - Equal operands give 0 for both ops.
  - Signed extremes: 0x80000000 is less than 0x7FFFFFFF.

Decomposition:
- Shared package: op-code constants CMP_LT = 2'b00 and CMP_GT = 2'b01, the result constants, and a round-robin pick function (mask, pointer → index).
- Sub-module: the existing comparator block, instantiated once. The arbiter muxes the winning requester's operands and op into it and registers its output.
- The arbiter logic, the slot register and the counter stay in cmp_arbiter.

Test Plan:
1. Single op: requester 0 sends src1 = 5, src2 = 9, op = 00 with rsp_ready = 1.
   → req_ready[0] = 1 at cycle 0.
   → rsp_valid = 01 and rsp_data = 1 at cycle 1.
   → op_count = 1 at cycle 2.
2. Contention: both requesters hold req_valid = 1 continuously, rr_ptr = 0.
   → Grants alternate 0,1,0,1 on consecutive cycles with rsp_ready tied high.
   → rsp_valid alternates 01, 10.
3. Backpressure: requester 1 sends src1 = 0x80000000, src2 = 0x7FFFFFFF, op = 01. Hold rsp_ready[1] = 0 for 3 cycles.
   → rsp_data = 0 and rsp_valid = 10 held stable.
   → req_ready = 00 during the hold, even with requester 0 valid.
   → Requester 0 is granted in the drain cycle.
4. Illegal op: op = 11 with src1 = 3, src2 = 1.
   → rsp_data = 0 and rsp_illegal = 1.
   → Next legal op clears rsp_illegal.
5. Reset mid-op: assert rst_n = 0 asynchronously while the slot is FULL.
   → rsp_valid = 0, rr_ptr = 0 and op_count = 0 immediately.
   → No response after release until a new request arrives.
6. Wrap: preload traffic to drive op_count to 0xFFFF, then drain one result.
   → op_count = 0x0000.

Source files
------------

// File: rtl/cmp_arbiter_pkg.sv
// Shared definitions for the comparator arbiter: op codes, result constants
// and the round-robin pick helper.
package cmp_arbiter_pkg;

   localparam int MAX_REQ = 4;
   localparam int IDX_W   = 2;

   localparam logic [1:0]  CMP_LT = 2'b00;
   localparam logic [1:0]  CMP_GT = 2'b01;

   localparam logic [31:0] RESULT_TRUE  = 32'd1;
   localparam logic [31:0] RESULT_FALSE = 32'd0;

   typedef struct packed {
      logic             hit;
      logic [IDX_W-1:0] idx;
   } rr_pick_t;

   // Scan in descending order so the last match written is the first set bit
   // at or after ptr, walking upward with wrap.
   function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] mask,
                                        input logic [IDX_W-1:0]   ptr,
                                        input int                 num);
      rr_pick_t r;
      int       j;
      r = '0;
      for (int k = num - 1; k >= 0; k--) begin
         j = (int'(ptr) + k) % num;
         if (mask[j]) begin
            r.hit = 1'b1;
            r.idx = j[IDX_W-1:0];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/cmp_arbiter_unit.sv
// Signed 32-bit comparator: less-than, greater-than, or zero for illegal ops.
module cmp_arbiter_unit
   import cmp_arbiter_pkg::*;
(
   input  logic [31:0] src1,
   input  logic [31:0] src2,
   input  logic [1:0]  op,
   output logic [31:0] result,
   output logic        illegal
);

   always_comb begin
      // NOTE: default every output first so no path through the case leaves a
      // value unassigned, which would infer a latch.
      result  = RESULT_FALSE;
      illegal = op[1];
      case (op)
         CMP_LT:  result = ($signed(src1) < $signed(src2)) ? RESULT_TRUE : RESULT_FALSE;
         CMP_GT:  result = ($signed(src1) > $signed(src2)) ? RESULT_TRUE : RESULT_FALSE;
         default: result = RESULT_FALSE;
      endcase
   end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one signed comparator between NUM_REQ requesters,
// with a single registered result slot and a drained-result counter.
module cmp_arbiter
   import cmp_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int CNT_W   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [NUM_REQ*32-1:0] req_src1,
   input  logic [NUM_REQ*32-1:0] req_src2,
   input  logic [NUM_REQ*2-1:0]  req_op,
   output logic [NUM_REQ-1:0]    rsp_valid,
   input  logic [NUM_REQ-1:0]    rsp_ready,
   output logic [31:0]           rsp_data,
   output logic                  rsp_illegal,
   output logic [CNT_W-1:0]      op_count
);

   logic [IDX_W-1:0]   owner;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   next_ptr;
   logic [MAX_REQ-1:0] valid_pad;
   logic [MAX_REQ-1:0] ready_pad;
   rr_pick_t           pick;
   logic               slot_full;
   logic               drain;
   logic               slot_free;
   logic               xfer;
   logic [31:0]        mux_src1;
   logic [31:0]        mux_src2;
   logic [1:0]         mux_op;
   logic [31:0]        cmp_result;
   logic               cmp_illegal;

   assign valid_pad = MAX_REQ'(req_valid);
   assign ready_pad = MAX_REQ'(rsp_ready);

   // Only the owner's rsp_ready can drain the slot; other bits are ignored.
   assign slot_full = |rsp_valid;
   assign drain     = slot_full & ready_pad[owner];
   assign slot_free = ~slot_full | drain;

   assign pick     = rr_pick(valid_pad, rr_ptr, NUM_REQ);
   assign xfer     = slot_free & pick.hit;
   assign next_ptr = IDX_W'((int'(pick.idx) + 1) % NUM_REQ);

   always_comb begin
      req_ready = '0;
      mux_src1  = '0;
      mux_src2  = '0;
      mux_op    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick.idx == IDX_W'(i)) begin
            req_ready[i] = xfer;
            mux_src1     = req_src1[32*i +: 32];
            mux_src2     = req_src2[32*i +: 32];
            mux_op       = req_op[2*i +: 2];
         end
      end
   end

   cmp_arbiter_unit u_cmp (
      .src1    (mux_src1),
      .src2    (mux_src2),
      .op      (mux_op),
      .result  (cmp_result),
      .illegal (cmp_illegal)
   );

   // A drain without a new transfer empties the slot but keeps the last
   // rsp_data / rsp_illegal values visible.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         rsp_valid   <= '0;
         rsp_data    <= '0;
         rsp_illegal <= 1'b0;
         owner       <= '0;
         rr_ptr      <= '0;
         op_count    <= '0;
      end else begin
         if (drain) begin
            op_count <= op_count + 1'b1;
         end
         if (xfer) begin
            rsp_valid   <= req_ready;
            rsp_data    <= cmp_result;
            rsp_illegal <= cmp_illegal;
            owner       <= pick.idx;
            rr_ptr      <= next_ptr;
         end else if (drain) begin
            rsp_valid <= '0;
         end
      end
   end

endmodule

// File: tb/tb_cmp_arbiter.sv
// Scoreboard bench for cmp_arbiter: expected results are queued on each
// transfer predicted by a reference arbiter model and compared while held.
module tb_cmp_arbiter;

   localparam int N  = 2;
   localparam int CW = 16;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*32-1:0] req_src1;
   logic [N*32-1:0] req_src2;
   logic [N*2-1:0]  req_op;
   logic [N-1:0]    rsp_valid;
   logic [N-1:0]    rsp_ready;
   logic [31:0]     rsp_data;
   logic            rsp_illegal;
   logic [CW-1:0]   op_count;

   cmp_arbiter #(.NUM_REQ(N), .CNT_W(CW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_src1    (req_src1),
      .req_src2    (req_src2),
      .req_op      (req_op),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .rsp_illegal (rsp_illegal),
      .op_count    (op_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          owner;
      logic [31:0] data;
      logic        ill;
   } exp_t;

   exp_t          sb[$];
   int            n_vec;
   int            n_bad;
   int            m_ptr;
   logic [CW-1:0] m_count;
   logic [31:0]   m_data;
   logic          m_ill;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_cmp(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] op);
      case (op)
         2'b00:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         2'b01:   return ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      sb.delete();
      m_ptr   = 0;
      m_count = '0;
      m_data  = '0;
      m_ill   = 1'b0;
   endtask

   task automatic set_req(input int i, input logic v, input logic [31:0] a,
                          input logic [31:0] b, input logic [1:0] op);
      req_valid[i]        = v;
      req_src1[32*i +: 32] = a;
      req_src2[32*i +: 32] = b;
      req_op[2*i +: 2]     = op;
   endtask

   // Called just after a falling edge with inputs already driven.
   task automatic step();
      logic [N-1:0] exp_ready;
      logic         free;
      int           g;
      exp_t         e;
      #1;
      if (sb.size() != 0) begin
         chk("rsp_valid", 32'(rsp_valid), 32'(1 << sb[0].owner));
         chk("rsp_data", rsp_data, sb[0].data);
         chk("rsp_illegal", 32'(rsp_illegal), 32'(sb[0].ill));
      end else begin
         chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
         chk("rsp_data_hold", rsp_data, m_data);
         chk("rsp_illegal_hold", 32'(rsp_illegal), 32'(m_ill));
      end
      chk("op_count", 32'(op_count), 32'(m_count));
      free = (sb.size() == 0) || rsp_ready[sb[0].owner];
      g = -1;
      exp_ready = '0;
      if (free) begin
         for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (g < 0 && req_valid[i]) g = i;
         end
      end
      if (g >= 0) exp_ready[g] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      if (sb.size() != 0 && rsp_ready[sb[0].owner]) begin
         void'(sb.pop_front());
         m_count++;
      end
      if (g >= 0) begin
         e.owner = g;
         e.data  = ref_cmp(req_src1[32*g +: 32], req_src2[32*g +: 32], req_op[2*g +: 2]);
         e.ill   = req_op[2*g+1];
         sb.push_back(e);
         m_data = e.data;
         m_ill  = e.ill;
         m_ptr  = (g + 1) % N;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      req_valid = '0;
      req_src1  = '0;
      req_src2  = '0;
      req_op    = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rsp_ready = '0;
      #2 rst_n = 1'b0;
      #1;
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_op_count", 32'(op_count), 32'd0);
      chk("reset_rsp_data", rsp_data, 32'd0);
      chk("reset_rsp_illegal", 32'(rsp_illegal), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      rst_n = 1'b1;
      idle_inputs();
      rsp_ready = '0;
      @(negedge clk);
      do_reset();

      // Single op: 5 < 9 from requester 0.
      rsp_ready = 2'b11;
      set_req(0, 1'b1, 32'd5, 32'd9, 2'b00);
      step();
      idle_inputs();
      step();
      step();
      chk("single_op_count", 32'(op_count), 32'd1);

      // Contention from rr_ptr = 0: grants alternate 0,1,0,1.
      do_reset();
      rsp_ready = 2'b11;
      set_req(0, 1'b1, 32'd1, 32'd2, 2'b00);
      set_req(1, 1'b1, 32'd7, 32'd3, 2'b01);
      for (int c = 0; c < 6; c++) step();
      idle_inputs();
      step();

      // Backpressure on requester 1 with signed extremes under GT.
      set_req(1, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 2'b01);
      step();
      idle_inputs();
      set_req(0, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 2'b00);
      rsp_ready = 2'b01;
      for (int c = 0; c < 3; c++) step();
      chk("bp_hold_data", rsp_data, 32'd0);
      rsp_ready = 2'b11;
      step();
      idle_inputs();
      step();
      step();

      // Illegal op, then a legal op clears rsp_illegal; equal operands give 0.
      set_req(0, 1'b1, 32'd3, 32'd1, 2'b11);
      step();
      set_req(0, 1'b1, 32'hFFFF_FFFF, 32'd0, 2'b00);
      step();
      set_req(0, 1'b1, 32'd42, 32'd42, 2'b01);
      step();
      set_req(0, 1'b1, 32'd42, 32'd42, 2'b00);
      step();
      idle_inputs();
      step();
      step();

      // Reset while FULL after a requester-0 grant leaves rr_ptr = 1.
      set_req(0, 1'b1, 32'd1, 32'd5, 2'b00);
      rsp_ready = 2'b00;
      step();
      chk("pre_reset_full", 32'(rsp_valid), 32'd1);
      do_reset();
      for (int c = 0; c < 3; c++) step();
      rsp_ready = 2'b11;
      set_req(0, 1'b1, 32'd9, 32'd2, 2'b01);
      set_req(1, 1'b1, 32'd2, 32'd9, 2'b01);
      step();
      idle_inputs();
      step();
      step();

      // Random traffic with random backpressure.
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < N; i++)
            set_req(i, 1'($urandom_range(0, 1)), $urandom(), $urandom(), 2'($urandom_range(0, 3)));
         rsp_ready = 2'($urandom_range(0, 3));
         step();
      end
      idle_inputs();
      rsp_ready = 2'b11;
      step();
      step();

      // Counter wrap: 65535 drains reach all-ones, one more wraps to zero.
      do_reset();
      rsp_ready = 2'b11;
      for (int c = 0; c < 65535; c++) begin
         for (int i = 0; i < N; i++)
            set_req(i, 1'b1, $urandom(), $urandom(), 2'($urandom_range(0, 3)));
         step();
      end
      idle_inputs();
      step();
      chk("wrap_max", 32'(op_count), 32'h0000_FFFF);
      set_req(1, 1'b1, 32'd0, 32'd1, 2'b00);
      step();
      idle_inputs();
      step();
      chk("wrap_zero", 32'(op_count), 32'd0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
